slot_cmd_sequencer: RTL and testbench
=====================================

// Module: slot_cmd_sequencer
// PURPOSE
//  Upstream command source for the 4-slot occupancy state machine. Collects per-slot set/clear request
//  pulses, keeps a shadow occupancy vector, drops illegal requests, and issues one legal
//  (cmd_val, cmd_sel) command at a time on a cmd_en/cmd_ready handshake. Slots are picked by round-robin.
// PARAMETERS
//  N_SLOTS     4   number of slots; must equal 2**SEL_W
//  SEL_W       2   width of cmd_sel
//  DROP_CNT_W  8   width of drop counter (DROP_CNT_EN only)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset, synchronous, active-high
//  set_req    in   N_SLOTS     1-cycle pulse per slot: request occupy
//  clr_req    in   N_SLOTS     1-cycle pulse per slot: request release
//  cmd_en     out  1           command valid to state machine
//  cmd_val    out  1           1=set slot, 0=clear slot
//  cmd_sel    out  SEL_W       slot index
//  cmd_ready  in   1           downstream accepts command this cycle
//  occ        out  N_SLOTS     shadow occupancy (bit i = slot i occupied)
//  busy       out  1           any pending request or command outstanding
//  drop_cnt   out  DROP_CNT_W  dropped-request count (DROP_CNT_EN only)
// BEHAVIOUR
//  Reset: cmd_en=0, cmd_val=0, cmd_sel=0, occ=0, busy=0, pending regs=0, rr_ptr=0, drop_cnt=0, FSM=IDLE.
//  rst wins over every other event. Reset mid-handshake aborts the command, with no occ update.
//  Capture: each cycle, for slot i:
//   - set_req[i] & clr_req[i] in the same cycle: both dropped.
//   - set_req[i] while occ[i]=1 or set_pend[i]=1: dropped. Same for clr_req[i] while occ[i]=0 or clr_pend[i]=1.
//   - otherwise the request latches into set_pend[i] / clr_pend[i].
//   - A slot never holds both a set_pend and a clr_pend bit.
//  Legality is checked against occ after any same-cycle handshake update.
//  FSM states: IDLE, ISSUE, GAP.
//   - IDLE: if any pending bit is set, pick the first slot >= rr_ptr (mod N_SLOTS) that has one.
//     Register cmd_val=set_pend[s], cmd_sel=s, cmd_en=1, then go to ISSUE. Otherwise stay in IDLE.
//   - ISSUE: cmd_en, cmd_val, cmd_sel are held stable until cmd_ready=1. On that edge:
//     occ[s] <= cmd_val, clear pend[s], rr_ptr <= s+1 (wraps N_SLOTS-1 -> 0), cmd_en <= 0, go to GAP.
//   - GAP: one cycle with cmd_en=0, so each command is a single en pulse downstream. Then IDLE.
//  Latency: a request pulse at edge t makes cmd_en high after edge t+2 (capture, then select).
//  Throughput: at most one command per 3 cycles with cmd_ready tied high.
//  busy = |set_pend | |clr_pend | (FSM != IDLE).
//  A new request for slot s arriving in ISSUE for s is judged against the updated occ value.
// CONFIGURATION
//  SLOT_DROP_CNT_EN defined:
//   - drop_cnt increments by 1 per dropped request, saturating at all-ones.
//   - A same-cycle set+clr on one slot counts as 2.
//   - Drops on several slots in one cycle add their total count.
//  SLOT_DROP_CNT_EN undefined: drop_cnt port and counter are absent; drops are silent.
// STRUCTURE
//  Package slot_pkg:
//   - typedef enum logic [1:0] {IDLE, ISSUE, GAP} seq_state_t
//   - localparams N_SLOTS=4, SEL_W=2
//   - typedef logic [SEL_W-1:0] slot_sel_t
//  Sub-module rr_pick: combinational round-robin finder.
//   - Inputs: req[N_SLOTS], ptr.
//   - Outputs: found, idx.
//  Everything else is inline.
// TESTING
//  1 set_req=4'b0001 pulse, cmd_ready=1 -> cmd_en=1, val=1, sel=0 two cycles later; occ=4'b0001 after the handshake.
//  2 set_req=4'b1111 in one cycle, ready=1 -> commands with sel 0,1,2,3 in order, 3 cycles apart; occ=4'b1111; busy drops after the last GAP.
//  3 occ=4'b0010 then set_req[1] pulse -> no command issued, occ unchanged; drop_cnt=1 when SLOT_DROP_CNT_EN is defined.
//  4 cmd_ready held 0 for 5 cycles during ISSUE -> cmd_en, val, sel stable all 5 cycles; accepted on the 6th; occ updates once.
//  5 rr_ptr=2, pending on slots 0 and 3 -> slot 3 issued first, then slot 0 (wrap).
//  6 rst asserted during ISSUE -> next cycle cmd_en=0, occ=0, busy=0; a request after reset issues normally.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and sizes for the slot command sequencer and its round-robin picker.
package slot_pkg;

    localparam int N_SLOTS    = 4;
    localparam int SEL_W      = 2;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} seq_state_t;

    typedef logic [SEL_W-1:0] slot_sel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first requesting slot at or after ptr, wrapping modulo N_SLOTS.
module rr_pick
    import slot_pkg::*;
(
    input  logic [N_SLOTS-1:0] req,
    input  slot_sel_t          ptr,
    output logic               found,
    output slot_sel_t          idx
);

    slot_sel_t w_cand;

    // Walk from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            w_cand = ptr + slot_sel_t'(k);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/slot_cmd_sequencer.sv
// Collects slot set/clear requests, filters illegal ones against a shadow occupancy, and issues one
// command at a time. Optional dropped-request counter enabled by defining SLOT_DROP_CNT_EN.
module slot_cmd_sequencer
    import slot_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SLOTS-1:0] set_req,
    input  logic [N_SLOTS-1:0] clr_req,
    output logic               cmd_en,
    output logic               cmd_val,
    output slot_sel_t          cmd_sel,
    input  logic               cmd_ready,
    output logic [N_SLOTS-1:0] occ,
    output logic               busy,
`ifdef SLOT_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output seq_state_t         dbg_state
);

    // Handshake: cmd_en/cmd_val/cmd_sel stay stable from the cycle cmd_en rises until the edge where
    // cmd_ready=1 is seen with cmd_en=1; that edge is the transfer, and cmd_en then drops for one GAP cycle.

    seq_state_t         r_state, w_state_nxt;
    logic               r_cmd_en, w_cmd_en_nxt;
    logic               r_cmd_val, w_cmd_val_nxt;
    slot_sel_t          r_cmd_sel, w_cmd_sel_nxt;
    slot_sel_t          r_rr_ptr, w_rr_nxt;
    logic [N_SLOTS-1:0] r_occ, w_occ_hs;
    logic [N_SLOTS-1:0] r_set_pend, w_set_hs, w_set_nxt;
    logic [N_SLOTS-1:0] r_clr_pend, w_clr_hs, w_clr_nxt;
    logic               w_found;
    slot_sel_t          w_pick;

`ifdef SLOT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [3:0]            w_drops;
    logic [DROP_CNT_W:0]   w_drop_sum;
`endif

    rr_pick u_rr_pick (
        .req   (r_set_pend | r_clr_pend),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_pick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_en_nxt  = r_cmd_en;
        w_cmd_val_nxt = r_cmd_val;
        w_cmd_sel_nxt = r_cmd_sel;
        w_rr_nxt      = r_rr_ptr;
        w_occ_hs      = r_occ;
        w_set_hs      = r_set_pend;
        w_clr_hs      = r_clr_pend;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_cmd_en_nxt  = 1'b1;
                    w_cmd_val_nxt = r_set_pend[w_pick];
                    w_cmd_sel_nxt = w_pick;
                    w_state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    w_occ_hs[r_cmd_sel] = r_cmd_val;
                    w_set_hs[r_cmd_sel] = 1'b0;
                    w_clr_hs[r_cmd_sel] = 1'b0;
                    w_rr_nxt            = r_cmd_sel + slot_sel_t'(1);
                    w_cmd_en_nxt        = 1'b0;
                    w_state_nxt         = GAP;
                end
            end
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // New requests are judged against occupancy/pending as they stand after this cycle's handshake.
    always_comb begin
        w_set_nxt = w_set_hs;
        w_clr_nxt = w_clr_hs;
`ifdef SLOT_DROP_CNT_EN
        w_drops   = '0;
`endif
        for (int i = 0; i < N_SLOTS; i++) begin
            if (set_req[i] && clr_req[i]) begin
`ifdef SLOT_DROP_CNT_EN
                w_drops = w_drops + 4'd2;
`endif
            end else begin
                if (set_req[i]) begin
                    if (w_occ_hs[i] || w_set_hs[i]) begin
`ifdef SLOT_DROP_CNT_EN
                        w_drops = w_drops + 4'd1;
`endif
                    end else begin
                        w_set_nxt[i] = 1'b1;
                    end
                end
                if (clr_req[i]) begin
                    if (!w_occ_hs[i] || w_clr_hs[i]) begin
`ifdef SLOT_DROP_CNT_EN
                        w_drops = w_drops + 4'd1;
`endif
                    end else begin
                        w_clr_nxt[i] = 1'b1;
                    end
                end
            end
        end
    end

`ifdef SLOT_DROP_CNT_EN
    assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W + 1)'(w_drops);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum[DROP_CNT_W]) begin
            r_drop_cnt <= '1;
        end else begin
            r_drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cmd_en   <= 1'b0;
            r_cmd_val  <= 1'b0;
            r_cmd_sel  <= '0;
            r_rr_ptr   <= '0;
            r_occ      <= '0;
            r_set_pend <= '0;
            r_clr_pend <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd_en   <= w_cmd_en_nxt;
            r_cmd_val  <= w_cmd_val_nxt;
            r_cmd_sel  <= w_cmd_sel_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_occ      <= w_occ_hs;
            r_set_pend <= w_set_nxt;
            r_clr_pend <= w_clr_nxt;
        end
    end

    assign cmd_en    = r_cmd_en;
    assign cmd_val   = r_cmd_val;
    assign cmd_sel   = r_cmd_sel;
    assign occ       = r_occ;
    assign busy      = (|r_set_pend) | (|r_clr_pend) | (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_slot_cmd_sequencer.sv
// Directed bench for slot_cmd_sequencer: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_slot_cmd_sequencer;
    import slot_pkg::*;

    logic               clk;
    logic               rst;
    logic [N_SLOTS-1:0] set_req;
    logic [N_SLOTS-1:0] clr_req;
    logic               cmd_en;
    logic               cmd_val;
    slot_sel_t          cmd_sel;
    logic               cmd_ready;
    logic [N_SLOTS-1:0] occ;
    logic               busy;
    seq_state_t         dbg_state;
`ifdef SLOT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] set_v;
        logic [3:0] clr_v;
        logic       rdy;
        logic       en;
        logic       val;
        logic [1:0] sel;
        logic [3:0] occ_v;
        logic       busy_v;
        int         drop;
    } vec_t;

    vec_t tbl[$];

    slot_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .set_req   (set_req),
        .clr_req   (clr_req),
        .cmd_en    (cmd_en),
        .cmd_val   (cmd_val),
        .cmd_sel   (cmd_sel),
        .cmd_ready (cmd_ready),
        .occ       (occ),
        .busy      (busy),
`ifdef SLOT_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cmd(input logic v, input logic [1:0] s, input string nm);
        int n;
        n = 0;
        step();
        while (!cmd_en && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_en"}, 32'(cmd_en), 32'd1);
        chk({nm, "_val"}, 32'(cmd_val), 32'(v));
        chk({nm, "_sel"}, 32'(cmd_sel), 32'(s));
    endtask

    initial begin
        rst       = 1'b1;
        set_req   = '0;
        clr_req   = '0;
        cmd_ready = 1'b0;
        repeat (3) step();
        chk("rst_en", 32'(cmd_en), 32'd0);
        chk("rst_val", 32'(cmd_val), 32'd0);
        chk("rst_sel", 32'(cmd_sel), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef SLOT_DROP_CNT_EN
        chk("rst_drop", 32'(drop_cnt), 32'd0);
`endif
        rst = 1'b0;

        //                set      clr      rdy  en   val  sel   occ      busy drop
        tbl.push_back('{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0001, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0011, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0011, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0011, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0111, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0111, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b0111, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b0, 0});
        // set on an occupied slot, then set+clr on one slot in the same cycle
        tbl.push_back('{4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b0, 1});
        tbl.push_back('{4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b0, 3});
        tbl.push_back('{4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b1, 3});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 3});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 1'b1, 3});
        tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1110, 1'b0, 3});

        foreach (tbl[i]) begin
            set_req   = tbl[i].set_v;
            clr_req   = tbl[i].clr_v;
            cmd_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_en", i), 32'(cmd_en), 32'(tbl[i].en));
            chk($sformatf("v%0d_val", i), 32'(cmd_val), 32'(tbl[i].val));
            chk($sformatf("v%0d_sel", i), 32'(cmd_sel), 32'(tbl[i].sel));
            chk($sformatf("v%0d_occ", i), 32'(occ), 32'(tbl[i].occ_v));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy_v));
`ifdef SLOT_DROP_CNT_EN
            chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
`endif
        end
        set_req = '0;
        clr_req = '0;

        // Stall in ISSUE, then a clear for the same slot lands on the accepting edge
        cmd_ready = 1'b0;
        set_req   = 4'b0001;
        step();
        set_req = '0;
        chk("stall_cap_busy", 32'(busy), 32'd1);
        step();
        chk("stall_issue_en", 32'(cmd_en), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall%0d_en", k), 32'(cmd_en), 32'd1);
            chk($sformatf("stall%0d_val", k), 32'(cmd_val), 32'd1);
            chk($sformatf("stall%0d_sel", k), 32'(cmd_sel), 32'd0);
            chk($sformatf("stall%0d_occ", k), 32'(occ), 32'b1110);
        end
        cmd_ready = 1'b1;
        clr_req   = 4'b0001;
        step();
        clr_req = '0;
        chk("stall_acc_en", 32'(cmd_en), 32'd0);
        chk("stall_acc_occ", 32'(occ), 32'b1111);
        step();
        chk("samecyc_busy", 32'(busy), 32'd1);
        step();
        chk("samecyc_en", 32'(cmd_en), 32'd1);
        chk("samecyc_val", 32'(cmd_val), 32'd0);
        chk("samecyc_sel", 32'(cmd_sel), 32'd0);
        step();
        chk("samecyc_occ", 32'(occ), 32'b1110);
        step();
        chk("samecyc_idle_busy", 32'(busy), 32'd0);
`ifdef SLOT_DROP_CNT_EN
        chk("samecyc_drop", 32'(drop_cnt), 32'd3);
`endif

        // Move rr_ptr to 2, then pend slots 0 and 3: slot 3 must go first
        clr_req = 4'b0010;
        step();
        clr_req = '0;
        wait_cmd(1'b0, 2'd1, "rr_s1");
        step();
        step();
        chk("rr_s1_occ", 32'(occ), 32'b1100);
        set_req = 4'b0001;
        clr_req = 4'b1000;
        step();
        set_req = '0;
        clr_req = '0;
        wait_cmd(1'b0, 2'd3, "rr_first");
        wait_cmd(1'b1, 2'd0, "rr_wrap");
        step();
        step();
        chk("rr_occ", 32'(occ), 32'b0101);
        chk("rr_busy", 32'(busy), 32'd0);

        // Reset while a command is stalled in ISSUE
        cmd_ready = 1'b0;
        set_req   = 4'b0010;
        step();
        set_req = '0;
        wait_cmd(1'b1, 2'd1, "mid_issue");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_en", 32'(cmd_en), 32'd0);
        chk("mid_rst_occ", 32'(occ), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef SLOT_DROP_CNT_EN
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
`endif
        cmd_ready = 1'b1;
        set_req   = 4'b0100;
        step();
        set_req = '0;
        wait_cmd(1'b1, 2'd2, "post_rst");
        step();
        chk("post_rst_occ", 32'(occ), 32'b0100);
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
